// File: rtl/fnd_pkg.sv
// Shared constants and FSM encoding for the FND binary-to-BCD path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fnd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGITS    = 4;
  localparam int MAX_VALUE = 9999;
  localparam int BCD_W     = DIGIT_W * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 when the digit is 5 or more.
// Latency: purely combinational.
// Backpressure: none.
module bcd_add3
  import fnd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_nib,
  output logic [DIGIT_W-1:0] o_nib
);

  assign o_nib = (i_nib >= DIGIT_W'(5)) ? (i_nib + DIGIT_W'(3)) : i_nib;

endmodule

// File: rtl/bin2bcd_4digit.sv
// Iterative shift-and-add-3 binary to 4-digit BCD converter for the FND scan path.
// Latency: start accepted at edge k, digits loaded and o_done high after edge k+IN_W, idle again after k+IN_W+1.
// Backpressure: i_start is only sampled in IDLE; requests while busy are dropped, not queued.
module bin2bcd_4digit #(
  parameter int IN_W      = 14,
  parameter int MAX_VALUE = fnd_pkg::MAX_VALUE
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  input  logic [IN_W-1:0]             i_value,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_overflow,
  output logic [fnd_pkg::DIGIT_W-1:0] o_1000,
  output logic [fnd_pkg::DIGIT_W-1:0] o_100,
  output logic [fnd_pkg::DIGIT_W-1:0] o_10,
  output logic [fnd_pkg::DIGIT_W-1:0] o_1
);

  import fnd_pkg::*;

  localparam int                CNT_W     = $clog2(IN_W);
  localparam logic [IN_W-1:0]   MAX_V     = IN_W'(MAX_VALUE);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(IN_W - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IN_W-1:0]    r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_flag;
  logic               r_overflow;
  logic [BCD_W-1:0]   r_digits;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BCD_W-1:0]   w_bcd_shf;
  logic               w_accept;
  logic               w_last;

  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == LAST_STEP);

  // Per-digit add-3 correction ahead of the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_bcd[g*DIGIT_W +: DIGIT_W]),
      .o_nib (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Anything carried out of the top digit is dropped: such values are
  // already flagged as overflow at capture and saturate at load time.
  assign w_bcd_shf = {w_bcd_adj[BCD_W-2:0], r_bin[IN_W-1]};

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; DONE always returns to IDLE so a held start repeats every IN_W+2 cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == LAST_STEP) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Working registers: capture on accept, then one correct-and-shift step per SHIFT cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
    end else if (w_accept) begin
      r_bin      <= i_value;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= (i_value > MAX_V);
    end else if (r_state == ST_SHIFT) begin
      r_bin <= {r_bin[IN_W-2:0], 1'b0};
      r_bcd <= w_bcd_shf;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Visible results change only on the final shift edge, so the display never shows partial values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_digits   <= '0;
      r_overflow <= 1'b0;
    end else if (w_last) begin
      r_digits   <= r_ovf_flag ? {DIGITS{DIGIT_W'(9)}} : w_bcd_shf;
      r_overflow <= r_ovf_flag;
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_overflow = r_overflow;
  assign o_1000     = r_digits[3*DIGIT_W +: DIGIT_W];
  assign o_100      = r_digits[2*DIGIT_W +: DIGIT_W];
  assign o_10       = r_digits[1*DIGIT_W +: DIGIT_W];
  assign o_1        = r_digits[0*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_bin2bcd_4digit.sv
// Self-checking bench for bin2bcd_4digit: directed and random conversions vs. an arithmetic model.
// Latency: checks a fixed 14-edge accept-to-done delay.
// Backpressure: checks that starts while busy are dropped.
module tb_bin2bcd_4digit;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_start;
  logic [13:0] i_value;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;
  logic [3:0]  o_1000;
  logic [3:0]  o_100;
  logic [3:0]  o_10;
  logic [3:0]  o_1;
  logic [15:0] dig;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] m_digits;
  logic        m_ovf;

  bin2bcd_4digit #(.IN_W(14), .MAX_VALUE(9999)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_start    (i_start),
    .i_value    (i_value),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow),
    .o_1000     (o_1000),
    .o_100      (o_100),
    .o_10       (o_10),
    .o_1        (o_1)
  );

  assign dig = {o_1000, o_100, o_10, o_1};

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: saturate, then split into decimal digits with plain arithmetic.
  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One conversion from IDLE; optionally fires a stray start 5 edges after accept.
  task automatic run_conv(input logic [13:0] v, input bit intrude, input logic [13:0] iv);
    int n;
    bit hold_ok;
    @(negedge i_clk);
    i_value = v;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("busy_after_accept", 32'(o_busy), 32'd1);
    n = 0;
    hold_ok = 1'b1;
    while (o_done !== 1'b1 && n < 40) begin
      if (dig !== m_digits || o_overflow !== m_ovf) hold_ok = 1'b0;
      if (intrude && n == 4) begin
        i_value = iv;
        i_start = 1'b1;
      end else if (intrude && n == 5) begin
        i_start = 1'b0;
      end
      @(posedge i_clk); #1;
      n++;
    end
    chk("digits_held_during_conv", 32'(hold_ok), 32'd1);
    chk("done_latency", 32'(n), 32'd14);
    m_digits = ref_bcd(int'(v));
    m_ovf    = (v > 14'd9999);
    chk("digits", 32'(dig), 32'(m_digits));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("busy_in_done", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    chk("done_single_cycle", 32'(o_done), 32'd0);
    chk("idle_after_done", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int n_done;
    int last_t;
    bit prev_done;
    bit consec;
    int w;

    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_value   = '0;
    m_digits  = '0;
    m_ovf     = 1'b0;
    #12;
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_overflow", 32'(o_overflow), 32'd0);
    chk("reset_digits", 32'(dig), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("idle_after_release", 32'(o_busy), 32'd0);

    // Basic conversion.
    run_conv(14'd9876, 1'b0, '0);

    // Back-to-back at the earliest legal start.
    run_conv(14'd0, 1'b0, '0);
    run_conv(14'd9999, 1'b0, '0);

    // Saturation, then recovery.
    run_conv(14'd10000, 1'b0, '0);
    run_conv(14'd16383, 1'b0, '0);
    run_conv(14'd42, 1'b0, '0);

    // Start while busy is dropped; following conversion keeps old digits until done.
    run_conv(14'd1234, 1'b1, 14'd5678);
    run_conv(14'd5678, 1'b0, '0);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge i_clk);
    i_value = 14'd4321;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(o_busy), 32'd0);
    chk("midreset_done", 32'(o_done), 32'd0);
    chk("midreset_overflow", 32'(o_overflow), 32'd0);
    chk("midreset_digits", 32'(dig), 32'd0);
    m_digits = '0;
    m_ovf    = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1) n_done++;
    end
    chk("no_done_after_abort", 32'(n_done), 32'd0);
    run_conv(14'd305, 1'b0, '0);

    // Start held high: one conversion every 16 cycles.
    @(negedge i_clk);
    i_value   = 14'd777;
    i_start   = 1'b1;
    n_done    = 0;
    last_t    = -1;
    prev_done = 1'b0;
    consec    = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1) begin
        n_done++;
        chk("held_start_digits", 32'(dig), 32'(ref_bcd(777)));
        if (prev_done) consec = 1'b1;
        if (last_t >= 0) chk("held_start_period", 32'(c - last_t), 32'd16);
        last_t = c;
      end
      prev_done = (o_done === 1'b1);
    end
    chk("held_start_count", 32'(n_done), 32'd3);
    chk("held_start_no_consec_done", 32'(consec), 32'd0);
    i_start  = 1'b0;
    m_digits = ref_bcd(777);
    m_ovf    = 1'b0;
    w = 0;
    while (o_busy !== 1'b0 && w < 40) begin
      @(posedge i_clk); #1;
      w++;
    end
    chk("idle_after_held_start", 32'(o_busy), 32'd0);

    // Random values across the full input range, including saturating ones.
    repeat (8) run_conv(14'($urandom_range(0, 16383)), 1'b0, '0);
    repeat (4) run_conv(14'($urandom_range(0, 9999)), 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bin2bcd_4digit.md
Name: bin2bcd_4digit

Overview:
Sequential binary-to-BCD converter for the 4-digit FND path. It takes a 14-bit binary count (0-9999) and produces the thousands, hundreds, tens and ones digits that the FND digit-select multiplexer scans. The conversion is an iterative shift-and-add-3 (double-dabble) with a start/done handshake. Output digits stay registered and stable while a new conversion runs, so the display never flickers on intermediate values.

Parameters:
IN_W, 14, binary input width; must cover MAX_VALUE.
MAX_VALUE, 9999, largest displayable value; anything above this saturates.

Ports:
i_clk  input  1  system clock, rising edge
i_reset_n  input  1  asynchronous active-low reset
i_start  input  1  request a conversion of i_value; sampled only in IDLE
i_value  input  IN_W  binary value, captured on the accepting edge
o_busy  output  1  high while a conversion is in progress
o_done  output  1  one-cycle pulse when the digit outputs are updated
o_overflow  output  1  registered; 1 if the last captured value was greater than MAX_VALUE
o_1000  output  4  thousands digit (BCD)
o_100  output  4  hundreds digit (BCD)
o_10  output  4  tens digit (BCD)
o_1  output  4  ones digit (BCD)

Behaviour:
- Reset (async, i_reset_n=0): state goes to IDLE. All outputs go to 0 (digits 0, o_busy=0, o_done=0, o_overflow=0). Internal shift and BCD registers and the step counter are cleared. Reset mid-conversion aborts it; no done pulse follows.
- States:
  - IDLE: when i_start=1 at edge k, capture i_value into the shift register, clear the BCD accumulator and step counter, set the overflow flag as (i_value > MAX_VALUE), and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: on each edge, apply add-3 to every BCD nibble that is 5 or more, then shift {bcd, bin} left by 1. The counter runs 0 to IN_W-1.
    - On the edge where counter = IN_W-1 (edge k+14), load o_1000..o_1 and o_overflow, then go to DONE.
    - If the flag is set, the digits load as 9,9,9,9.
    - The full 14 steps always run, so latency is constant.
  - DONE: o_done=1 for exactly this one cycle, then go to IDLE unconditionally. i_start is ignored in DONE.
- o_busy = 1 in SHIFT and DONE; 0 in IDLE. It is registered (state-decoded from registered state).
- i_start while busy is ignored; it is not queued.
- Latency: start accepted at edge k; o_done is high in the cycle after edge k+14. The next start is accepted at the earliest at edge k+16.
- Digit outputs hold their last value between conversions and during reset release. They change only at the load edge.
- The BCD accumulator is 16 bits. Its upper bits beyond the 4th digit are not needed because overflow is resolved at capture. Values up to 16383 must not corrupt state.

Decomposition:
- Shared package fnd_pkg holds:
  - DIGIT_W=4
  - MAX_VALUE=9999
  - the state encoding (IDLE, SHIFT, DONE)
  - DIGITS=4
- One sub-module, bcd_add3: a 4-bit combinational nibble correction (adds 3 if the input is 5 or more). It is instantiated once per digit.

Test Plan:
- i_value=9876, pulse i_start -> o_done high 15 cycles after the accepting edge; digits 9,8,7,6; o_overflow=0.
- i_value=0, then i_value=9999 back-to-back (second start at earliest legal edge) -> 0,0,0,0 then 9,9,9,9; exactly one done pulse each.
- i_value=10000 and then 16383 -> o_overflow=1, digits 9,9,9,9; then i_value=42 -> o_overflow=0, digits 0,0,4,2.
- Convert 1234, then start with i_value=5678 while o_busy=1 (cycle 5) -> request ignored; result 1,2,3,4; digits unchanged during the following conversion of 5678 until its done.
- Drive i_reset_n low asynchronously mid-SHIFT (between clock edges) -> all outputs 0 immediately; no o_done; a subsequent start of 305 gives 0,3,0,5.
- Hold i_start=1 continuously with i_value=777 -> a conversion every 16 cycles, each giving 0,7,7,7; o_done is never high on consecutive cycles.
